// File: rtl/md_issue_ctrl_if.sv
// Start/write handshake between the E-stage issue controller and the HI/LO multiply/divide unit.
interface md_issue_ctrl_if;
    logic [3:0] hlu_type;
    logic       hlu_unsigned;
    logic       hlu_write;
    logic       hlu_dst;
    logic       hlu_busy;

    modport master (
        output hlu_type,
        output hlu_unsigned,
        output hlu_write,
        output hlu_dst,
        input  hlu_busy
    );

    modport slave (
        input  hlu_type,
        input  hlu_unsigned,
        input  hlu_write,
        input  hlu_dst,
        output hlu_busy
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage initiator for the HI/LO mult/div unit: issues ops, tracks busy, stalls D, watchdogs the unit.
// Optional perf counters are built when MD_PERF_CNT_EN is defined; otherwise perf outputs read 0.
module md_issue_ctrl #(
    parameter int MUL_BUSY = 5,
    parameter int DIV_BUSY = 10,
    parameter int SLACK    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          e_valid,
    input  logic [2:0]    e_class,
    input  logic          d_md_use,
    md_issue_ctrl_if.master hlu,
    output logic          stall_d,
    output logic          err,
    output logic [31:0]   perf_issue,
    output logic [31:0]   perf_stall
);

    typedef enum logic [1:0] {IDLE, ISSUED, BUSY} state_t;

    localparam logic [4:0] MUL_EXP = 5'(MUL_BUSY);
    localparam logic [4:0] DIV_EXP = 5'(DIV_BUSY);
    localparam logic [4:0] SLACK_W = 5'(SLACK);

    state_t     state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic [4:0] exp_cnt, exp_nxt;
    logic [4:0] limit;
    logic       err_q, err_set;
    logic       is_op, is_div, issue, wr;

    assign is_op  = (e_class inside {3'd1, 3'd2, 3'd3, 3'd4});
    assign is_div = (e_class inside {3'd3, 3'd4});
    assign issue  = e_valid & ~req & (state == IDLE) & is_op;
    assign wr     = e_valid & ~req & (e_class inside {3'd5, 3'd6});
    assign limit  = exp_cnt + SLACK_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            exp_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            exp_cnt <= exp_nxt;
            err_q   <= err_q | err_set;
        end
    end

    // Everything holds while req is up because the unit freezes alongside us.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        exp_nxt   = exp_cnt;
        err_set   = 1'b0;
        if (!req && !reset) begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state_nxt = ISSUED;
                        exp_nxt   = is_div ? DIV_EXP : MUL_EXP;
                        cnt_nxt   = '0;
                    end
                end
                ISSUED: begin
                    if (hlu.hlu_busy) begin
                        state_nxt = BUSY;
                        cnt_nxt   = 5'd1;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BUSY: begin
                    if (!hlu.hlu_busy) begin
                        state_nxt = IDLE;
                    end else if (cnt >= limit) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end else if (cnt != 5'd31) begin
                        cnt_nxt = cnt + 5'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stall covers the start cycle itself since the unit's busy rises a cycle late.
    always_comb begin
        hlu.hlu_type     = 4'b0000;
        hlu.hlu_unsigned = 1'b0;
        if (issue) begin
            hlu.hlu_type     = is_div ? 4'b0010 : 4'b0001;
            hlu.hlu_unsigned = (e_class == 3'd2) || (e_class == 3'd4);
        end
        hlu.hlu_write = wr;
        hlu.hlu_dst   = wr & (e_class == 3'd5);
        stall_d       = d_md_use & (issue | (state != IDLE) | hlu.hlu_busy);
        err           = err_q | err_set;
    end

`ifdef MD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (issue)   perf_issue <= perf_issue + 32'd1;
            if (stall_d) perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    assign perf_issue = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural mult/div unit that freezes under req.
module tb_md_issue_ctrl;

    localparam int MUL_BUSY = 5;
    localparam int DIV_BUSY = 10;
    localparam int SLACK    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        e_valid = 1'b0;
    logic [2:0]  e_class = 3'd0;
    logic        d_md_use = 1'b0;
    logic        stall_d, err;
    logic [31:0] perf_issue, perf_stall;

    int errors = 0;
    int checks = 0;
    int unit_len = 0;
    int rem = 0;

    md_issue_ctrl_if hlu();

    md_issue_ctrl #(
        .MUL_BUSY(MUL_BUSY),
        .DIV_BUSY(DIV_BUSY),
        .SLACK   (SLACK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .e_valid   (e_valid),
        .e_class   (e_class),
        .d_md_use  (d_md_use),
        .hlu       (hlu),
        .stall_d   (stall_d),
        .err       (err),
        .perf_issue(perf_issue),
        .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    // Model unit: busy is visible from the cycle after start and lasts unit_len cycles.
    always @(posedge clk) begin
        if (reset) rem <= 0;
        else if (!req) begin
            if (hlu.hlu_type != 4'b0000) rem <= unit_len;
            else if (rem > 0)            rem <= rem - 1;
        end
    end
    assign hlu.hlu_busy = (rem != 0);

    task automatic do_reset();
        reset = 1'b1; req = 1'b0; e_valid = 1'b0; e_class = 3'd0; d_md_use = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; e_valid = 1'b1; e_class = 3'd6; d_md_use = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (hlu.hlu_write !== 1'b1) begin errors++; $display("[TB] FAIL reset_write_follow got=%b exp=1", hlu.hlu_write); end
        @(posedge clk); #1;
        reset = 1'b0; e_valid = 1'b0; e_class = 3'd0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
        checks++;
        if (stall_d !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", stall_d); end
        checks++;
        if (hlu.hlu_type !== 4'b0000) begin errors++; $display("[TB] FAIL reset_type got=%b exp=0000", hlu.hlu_type); end
        checks++;
        if (perf_issue !== 32'd0 || perf_stall !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_perf got=%0d/%0d exp=0/0", perf_issue, perf_stall);
        end
        @(posedge clk); #1;
        d_md_use = 1'b0;
    endtask

    task automatic test_mult();
        unit_len = MUL_BUSY - 1;
        d_md_use = 1'b1; e_class = 3'd1;
        for (int c = 0; c < 8; c++) begin
            e_valid = (c == 0);
            @(negedge clk);
            checks++;
            if (hlu.hlu_type !== ((c == 0) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("[TB] FAIL mult_type c=%0d got=%b", c, hlu.hlu_type);
            end
            checks++;
            if (stall_d !== (c <= 5)) begin errors++; $display("[TB] FAIL mult_stall c=%0d got=%b exp=%b", c, stall_d, c <= 5); end
            checks++;
            if (err !== 1'b0) begin errors++; $display("[TB] FAIL mult_err c=%0d got=%b exp=0", c, err); end
            @(posedge clk); #1;
        end
        d_md_use = 1'b0; e_class = 3'd0;
    endtask

    task automatic test_divu();
        unit_len = DIV_BUSY - 1;
        d_md_use = 1'b1; e_class = 3'd4;
        for (int c = 0; c < 13; c++) begin
            e_valid = (c == 0);
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (hlu.hlu_type !== 4'b0010 || hlu.hlu_unsigned !== 1'b1) begin
                    errors++; $display("[TB] FAIL divu_start got=%b/%b exp=0010/1", hlu.hlu_type, hlu.hlu_unsigned);
                end
            end
            checks++;
            if (stall_d !== (c <= 10)) begin errors++; $display("[TB] FAIL divu_stall c=%0d got=%b exp=%b", c, stall_d, c <= 10); end
            @(posedge clk); #1;
        end
        d_md_use = 1'b0; e_class = 3'd0;
    endtask

    task automatic test_write();
        logic [2:0] cls [5] = '{3'd6, 3'd5, 3'd7, 3'd6, 3'd6};
        logic       vld [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       rq  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       ew  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ed  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            e_class = cls[i]; e_valid = vld[i]; req = rq[i];
            @(negedge clk);
            checks++;
            if (hlu.hlu_write !== ew[i] || hlu.hlu_dst !== ed[i] || hlu.hlu_type !== 4'b0000 || stall_d !== 1'b0) begin
                errors++;
                $display("[TB] FAIL write_vec%0d got wr=%b dst=%b type=%b stall=%b exp wr=%b dst=%b type=0000 stall=0",
                         i, hlu.hlu_write, hlu.hlu_dst, hlu.hlu_type, stall_d, ew[i], ed[i]);
            end
            @(posedge clk); #1;
        end
        e_valid = 1'b0; e_class = 3'd0; req = 1'b0;
    endtask

    task automatic test_req();
        unit_len = MUL_BUSY - 1;
        d_md_use = 1'b1; e_class = 3'd1; e_valid = 1'b1; req = 1'b1;
        @(negedge clk);
        checks++;
        if (hlu.hlu_type !== 4'b0000 || stall_d !== 1'b0) begin
            errors++; $display("[TB] FAIL req_suppress got type=%b stall=%b exp 0000/0", hlu.hlu_type, stall_d);
        end
        @(posedge clk); #1;
        req = 1'b0; e_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_d !== 1'b0) begin errors++; $display("[TB] FAIL req_no_issue got=%b exp=0", stall_d); end
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            e_valid = (c == 0);
            req = (c >= 2 && c <= 4);
            @(negedge clk);
            checks++;
            if (stall_d !== (c <= 8)) begin errors++; $display("[TB] FAIL req_stall c=%0d got=%b exp=%b", c, stall_d, c <= 8); end
            checks++;
            if (err !== 1'b0) begin errors++; $display("[TB] FAIL req_err c=%0d got=%b exp=0", c, err); end
            @(posedge clk); #1;
        end
        req = 1'b0; d_md_use = 1'b0; e_class = 3'd0;
    endtask

    task automatic test_watchdog_no_busy();
        do_reset();
        unit_len = 0;
        e_class = 3'd1;
        for (int c = 0; c < 5; c++) begin
            e_valid = (c == 0);
            @(negedge clk);
            checks++;
            if (err !== (c >= 1)) begin errors++; $display("[TB] FAIL nobusy_err c=%0d got=%b exp=%b", c, err, c >= 1); end
            @(posedge clk); #1;
        end
        e_class = 3'd0;
    endtask

    task automatic test_watchdog_timeout();
        do_reset();
        unit_len = 20;
        e_class = 3'd1; d_md_use = 1'b1;
        for (int c = 0; c < 13; c++) begin
            e_valid = (c == 0);
            @(negedge clk);
            checks++;
            if (err !== (c >= 10)) begin errors++; $display("[TB] FAIL timeout_err c=%0d got=%b exp=%b", c, err, c >= 10); end
            @(posedge clk); #1;
        end
        d_md_use = 1'b0; e_class = 3'd0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        unit_len = MUL_BUSY - 1;
        e_class = 3'd1; d_md_use = 1'b1;
        for (int c = 0; c < 4; c++) begin
            e_valid = (c == 0);
            reset = (c == 2);
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (stall_d !== 1'b0 || err !== 1'b0) begin
                    errors++; $display("[TB] FAIL reset_mid got stall=%b err=%b exp 0/0", stall_d, err);
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; d_md_use = 1'b0; e_class = 3'd0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        unit_len = MUL_BUSY - 1;
        e_class = 3'd1;
        for (int c = 0; c < 14; c++) begin
            e_valid = (c == 0 || c == 6);
            d_md_use = (c < 12);
            @(negedge clk);
            if (c == 6) begin
                checks++;
                if (hlu.hlu_type !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_second_issue got=%b exp=0001", hlu.hlu_type); end
            end
            checks++;
            if (stall_d !== (c < 12)) begin errors++; $display("[TB] FAIL b2b_stall c=%0d got=%b exp=%b", c, stall_d, c < 12); end
            @(posedge clk); #1;
        end
        @(negedge clk);
`ifdef MD_PERF_CNT_EN
        checks++;
        if (perf_issue !== 32'd2) begin errors++; $display("[TB] FAIL perf_issue got=%0d exp=2", perf_issue); end
        checks++;
        if (perf_stall !== 32'd12) begin errors++; $display("[TB] FAIL perf_stall got=%0d exp=12", perf_stall); end
`else
        checks++;
        if (perf_issue !== 32'd0 || perf_stall !== 32'd0) begin
            errors++; $display("[TB] FAIL perf_tied got=%0d/%0d exp=0/0", perf_issue, perf_stall);
        end
`endif
        @(posedge clk); #1;
        e_class = 3'd0; d_md_use = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu();
        test_write();
        test_req();
        test_watchdog_no_busy();
        test_watchdog_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
